// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream input, the instruction-memory write port and the CPU
// control outputs of the instruction-memory loader.
//   load_i        : one-cycle request to begin a (re)load
//   byte_valid_i  : byte_data_i holds a program byte
//   byte_data_i   : program byte, little-endian within a 32-bit word
//   byte_ready_o  : loader accepts a byte this cycle
//   mem_we_o      : instruction-memory write strobe
//   mem_addr_o    : word address being written
//   mem_data_o    : word being written
//   cpu_rst_o     : active-low CPU reset, low while loading
//   start_o       : CPU start, high once loading is complete
//   word_count_o  : program words written, end marker included
// master = byte source / system side, slave = the loader.
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        load_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_rst_o;
    logic        start_o;
    logic [8:0]  word_count_o;

    modport master (
        output load_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               cpu_rst_o, start_o, word_count_o
    );

    modport slave (
        input  load_i, byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               cpu_rst_o, start_o, word_count_o
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Assembles a little-endian byte stream into 32-bit words and writes them into
// instruction memory starting at word BASE_OFFSET (wrapping modulo DEPTH).
// A zero word ends the program: it is written, then the rest of the memory is
// zero-filled. Once the memory is complete the CPU is released from reset and
// started. load_i at any time restarts the load from word 0.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : imem_loader_if.slave (byte stream, memory write port, CPU control)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH       = 256,
    parameter int BASE_OFFSET = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imem_loader_if.slave  bus
);
    localparam int AW = 8;
    localparam logic [AW-1:0] LAST_N    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] BASE      = AW'(BASE_OFFSET);
    localparam logic [8:0]    COUNT_MAX = 9'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    state_t        state;
    logic [1:0]    lane;      // next byte position within the current word
    logic [23:0]   partial;   // bytes 0..2 of the word being assembled
    logic [AW-1:0] n;         // index of the word being assembled / written
    logic          accept;

    assign accept = bus.byte_valid_i && bus.byte_ready_o;

    // NOTE: every state register uses non-blocking assignments so all of them
    // update together on the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: only control/output registers exist here (no memory array),
        // so clearing everything on reset is cheap and makes outputs defined.
        if (!rst_i) begin
            state            <= IDLE;
            lane             <= 2'd0;
            partial          <= 24'd0;
            n                <= '0;
            bus.byte_ready_o <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_data_o   <= 32'd0;
            bus.cpu_rst_o    <= 1'b0;
            bus.start_o      <= 1'b0;
            bus.word_count_o <= 9'd0;
        end else if (bus.load_i) begin
            // Restart from any state; a byte offered in this cycle is dropped
            // and any partially assembled word is discarded.
            state            <= LOAD;
            lane             <= 2'd0;
            partial          <= 24'd0;
            n                <= '0;
            bus.byte_ready_o <= 1'b1;
            bus.mem_we_o     <= 1'b0;
            bus.cpu_rst_o    <= 1'b0;
            bus.start_o      <= 1'b0;
            bus.word_count_o <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                end

                LOAD: begin
                    if (bus.mem_we_o) begin
                        // Write cycle of word n: decide what follows it.
                        bus.mem_we_o <= 1'b0;
                        if (bus.mem_data_o == 32'd0) begin
                            state <= FILL;
                        end else if (n == LAST_N) begin
                            state         <= DONE;
                            bus.cpu_rst_o <= 1'b1;
                            bus.start_o   <= 1'b1;
                        end else begin
                            n                <= n + 1'b1;
                            bus.byte_ready_o <= 1'b1;
                        end
                    end else if (accept) begin
                        if (lane == 2'd3) begin
                            bus.mem_we_o     <= 1'b1;
                            bus.mem_addr_o   <= BASE + n;
                            bus.mem_data_o   <= {bus.byte_data_i, partial};
                            bus.byte_ready_o <= 1'b0;
                            lane             <= 2'd0;
                            if (bus.word_count_o != COUNT_MAX)
                                bus.word_count_o <= bus.word_count_o + 9'd1;
                        end else begin
                            partial[lane*8 +: 8] <= bus.byte_data_i;
                            lane                 <= lane + 2'd1;
                        end
                    end
                end

                FILL: begin
                    // n tracks the last word written; zero the rest, one per cycle.
                    if (n == LAST_N) begin
                        bus.mem_we_o  <= 1'b0;
                        state         <= DONE;
                        bus.cpu_rst_o <= 1'b1;
                        bus.start_o   <= 1'b1;
                    end else begin
                        n              <= n + 1'b1;
                        bus.mem_we_o   <= 1'b1;
                        bus.mem_addr_o <= BASE + n + AW'(1);
                        bus.mem_data_o <= 32'd0;
                    end
                end

                DONE: begin
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Programs are random byte streams; the
// expected memory writes and word count are computed from the loading rules
// (word k -> address (BASE + k) mod DEPTH, zero word ends and zero-fills).
// -----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int BASE  = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH), .BASE_OFFSET(BASE)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        got[$];
    wr_t        exp_q[$];
    logic [7:0] prog[$];
    int         exp_count;
    int         compared   = 0;
    int         mismatched = 0;

    // Record every memory write the DUT issues.
    always @(negedge clk_i) begin
        if (bus.mem_we_o === 1'b1)
            got.push_back('{int'(bus.mem_addr_o), bus.mem_data_o});
    end

    // ---------------------------------------------------------------- model
    task automatic build_expected();
        int          nwords;
        logic [31:0] w;
        exp_q.delete();
        exp_count = 0;
        nwords = prog.size() / 4;
        for (int k = 0; k < nwords && k < DEPTH; k++) begin
            w = {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
            exp_q.push_back('{(BASE + k) % DEPTH, w});
            exp_count = (k + 1 > DEPTH) ? DEPTH : k + 1;
            if (w == 32'd0) begin
                for (int j = k + 1; j < DEPTH; j++)
                    exp_q.push_back('{(BASE + j) % DEPTH, 32'd0});
                break;
            end
        end
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic gen_program(input int nwords, input bit marker);
        logic [31:0] w;
        prog.delete();
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            if (w == 32'd0) w = 32'h1;
            for (int b = 0; b < 4; b++) prog.push_back(w[8*b +: 8]);
        end
        if (marker)
            for (int b = 0; b < 4; b++) prog.push_back(8'h00);
    endtask

    task automatic pulse_load();
        @(negedge clk_i);
        bus.load_i = 1'b1;
        @(negedge clk_i);
        bus.load_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t;
        @(negedge clk_i);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        t = 0;
        while (bus.byte_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        ok = (t < 50);
        if (ok) @(posedge clk_i);
    endtask

    task automatic send_program(input bit gap, output int timeouts);
        bit ok;
        timeouts = 0;
        foreach (prog[i]) begin
            send_byte(prog[i], ok);
            if (!ok) begin
                timeouts++;
                break;
            end
            if (gap) begin
                @(negedge clk_i);
                bus.byte_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        while (bus.start_o !== 1'b1 && t < 600) begin
            @(negedge clk_i);
            t++;
        end
        ok = (bus.start_o === 1'b1);
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        compared++;
        if ({bus.byte_ready_o, bus.mem_we_o, bus.cpu_rst_o, bus.start_o} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: ready/we/cpu_rst/start=%b expected 0000",
                     {bus.byte_ready_o, bus.mem_we_o, bus.cpu_rst_o, bus.start_o});
        end
        compared++;
        if (bus.mem_addr_o !== 8'd0 || bus.mem_data_o !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_bus: addr=%h data=%h expected 0/0", bus.mem_addr_o, bus.mem_data_o);
        end
        compared++;
        if (bus.word_count_o !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_count: got %0d expected 0", bus.word_count_o);
        end
        rst_i = 1'b1;
        // Bytes offered in IDLE are ignored.
        got.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            bus.byte_valid_i = i[0];
            bus.byte_data_i  = 8'($urandom);
        end
        bus.byte_valid_i = 1'b0;
        @(negedge clk_i);
        compared++;
        if (got.size() != 0 || bus.byte_ready_o !== 1'b0 || bus.start_o !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ignore: writes=%0d ready=%b start=%b expected 0/0/0",
                     got.size(), bus.byte_ready_o, bus.start_o);
        end
    endtask

    task automatic test_example();
        int tmo;
        bit ok;
        got.delete();
        prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_load();
        send_program(1'b0, tmo);
        wait_done(ok);
        compared++;
        if (tmo != 0 || !ok) begin
            mismatched++;
            $display("FAIL example_progress: timeouts=%0d done=%0b expected 0/1", tmo, ok);
        end
        compared++;
        if (got.size() < 2 || got[0].addr != 2 || got[0].data !== 32'h00000513 ||
            got[1].addr != 3 || got[1].data !== 32'h0) begin
            mismatched++;
            $display("FAIL example_first_writes: got %0d writes, expected 513@2 then 0@3", got.size());
        end
        compared++;
        if (got.size() != 256 || got[255].addr != 1) begin
            mismatched++;
            $display("FAIL example_fill: writes=%0d expected 256 ending at addr 1", got.size());
        end
        compared++;
        if (bus.word_count_o !== 9'd2 || bus.start_o !== 1'b1 || bus.cpu_rst_o !== 1'b1) begin
            mismatched++;
            $display("FAIL example_done: count=%0d start=%b cpu_rst=%b expected 2/1/1",
                     bus.word_count_o, bus.start_o, bus.cpu_rst_o);
        end
    endtask

    task automatic test_random_programs();
        int tmo;
        bit ok;
        bit gap;
        for (int it = 0; it < 4; it++) begin
            gen_program($urandom_range(1, 12), 1'b1);
            gap = 1'(it);
            build_expected();
            got.delete();
            pulse_load();
            send_program(gap, tmo);
            wait_done(ok);
            compared++;
            if (tmo != 0 || !ok || got.size() != exp_q.size()) begin
                mismatched++;
                $display("FAIL rand%0d_size: writes=%0d expected %0d (timeouts=%0d done=%0b)",
                         it, got.size(), exp_q.size(), tmo, ok);
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                compared++;
                if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                    mismatched++;
                    $display("FAIL rand%0d_write[%0d]: got %h@%0d expected %h@%0d", it, i,
                             got[i].data, got[i].addr, exp_q[i].data, exp_q[i].addr);
                end
            end
            compared++;
            if (bus.word_count_o !== 9'(exp_count) || bus.byte_ready_o !== 1'b0 ||
                bus.mem_we_o !== 1'b0 || bus.cpu_rst_o !== 1'b1) begin
                mismatched++;
                $display("FAIL rand%0d_done: count=%0d ready=%b we=%b cpu_rst=%b expected %0d/0/0/1",
                         it, bus.word_count_o, bus.byte_ready_o, bus.mem_we_o, bus.cpu_rst_o, exp_count);
            end
        end
    endtask

    task automatic test_full();
        int tmo;
        bit ok;
        gen_program(DEPTH, 1'b0);
        build_expected();
        got.delete();
        pulse_load();
        send_program(1'b0, tmo);
        wait_done(ok);
        compared++;
        if (tmo != 0 || !ok || got.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL full_size: writes=%0d expected %0d (timeouts=%0d done=%0b)",
                     got.size(), exp_q.size(), tmo, ok);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                mismatched++;
                $display("FAIL full_write[%0d]: got %h@%0d expected %h@%0d", i,
                         got[i].data, got[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
        compared++;
        if (bus.word_count_o !== 9'd256 || bus.byte_ready_o !== 1'b0 || bus.start_o !== 1'b1) begin
            mismatched++;
            $display("FAIL full_done: count=%0d ready=%b start=%b expected 256/0/1",
                     bus.word_count_o, bus.byte_ready_o, bus.start_o);
        end
        // Further bytes after the memory is full are not accepted.
        @(negedge clk_i);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'h5A;
        repeat (8) @(negedge clk_i);
        bus.byte_valid_i = 1'b0;
        compared++;
        if (got.size() != DEPTH || bus.word_count_o !== 9'd256) begin
            mismatched++;
            $display("FAIL full_extra: writes=%0d count=%0d expected 256/256", got.size(), bus.word_count_o);
        end
    endtask

    task automatic test_restart();
        int tmo;
        logic [31:0] w0;
        bit ok;
        got.delete();
        gen_program(1, 1'b0);
        w0 = {prog[3], prog[2], prog[1], prog[0]};
        prog.push_back(8'hA1);
        prog.push_back(8'hB2);
        pulse_load();
        send_program(1'b0, tmo);
        pulse_load();
        gen_program(3, 1'b1);
        build_expected();
        exp_q.push_front('{BASE, w0});
        send_program(1'b0, tmo);
        wait_done(ok);
        compared++;
        if (tmo != 0 || !ok || got.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL restart_size: writes=%0d expected %0d (timeouts=%0d done=%0b)",
                     got.size(), exp_q.size(), tmo, ok);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                mismatched++;
                $display("FAIL restart_write[%0d]: got %h@%0d expected %h@%0d", i,
                         got[i].data, got[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
        compared++;
        if (bus.word_count_o !== 9'(exp_count)) begin
            mismatched++;
            $display("FAIL restart_count: got %0d expected %0d", bus.word_count_o, exp_count);
        end
    endtask

    task automatic test_collision();
        int tmo;
        bit ok;
        bit rdy;
        got.delete();
        pulse_load();
        prog = '{8'hEE};
        send_program(1'b0, tmo);
        @(negedge clk_i);
        rdy = bus.byte_ready_o;
        bus.load_i       = 1'b1;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'h77;
        @(negedge clk_i);
        bus.load_i       = 1'b0;
        bus.byte_valid_i = 1'b0;
        compared++;
        if (rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL collide_ready: ready=%b expected 1 when load coincides with a byte", rdy);
        end
        gen_program(2, 1'b1);
        build_expected();
        send_program(1'b0, tmo);
        wait_done(ok);
        compared++;
        if (tmo != 0 || !ok || got.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL collide_size: writes=%0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < 3 && i < got.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                mismatched++;
                $display("FAIL collide_write[%0d]: got %h@%0d expected %h@%0d", i,
                         got[i].data, got[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_reset_in_fill();
        int tmo;
        int t;
        got.delete();
        pulse_load();
        gen_program(1, 1'b1);
        send_program(1'b0, tmo);
        t = 0;
        while (got.size() < 6 && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        compared++;
        if (bus.mem_we_o !== 1'b1 || bus.start_o !== 1'b0) begin
            mismatched++;
            $display("FAIL fill_active: we=%b start=%b expected 1/0 while filling", bus.mem_we_o, bus.start_o);
        end
        #1 rst_i = 1'b0;
        #1;
        compared++;
        if (bus.mem_we_o !== 1'b0 || bus.cpu_rst_o !== 1'b0 || bus.word_count_o !== 9'd0) begin
            mismatched++;
            $display("FAIL fill_async_reset: we=%b cpu_rst=%b count=%0d expected 0/0/0",
                     bus.mem_we_o, bus.cpu_rst_o, bus.word_count_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        got.delete();
        bus.byte_valid_i = 1'b1;
        repeat (20) @(negedge clk_i);
        bus.byte_valid_i = 1'b0;
        compared++;
        if (got.size() != 0 || bus.byte_ready_o !== 1'b0 || bus.start_o !== 1'b0) begin
            mismatched++;
            $display("FAIL after_reset_idle: writes=%0d ready=%b start=%b expected 0/0/0",
                     got.size(), bus.byte_ready_o, bus.start_o);
        end
    endtask

    task automatic test_reload_done();
        int tmo;
        bit ok;
        pulse_load();
        gen_program(2, 1'b1);
        send_program(1'b0, tmo);
        wait_done(ok);
        @(negedge clk_i);
        bus.load_i = 1'b1;
        @(posedge clk_i);
        #1;
        compared++;
        if (bus.start_o !== 1'b0 || bus.cpu_rst_o !== 1'b0 || bus.word_count_o !== 9'd0) begin
            mismatched++;
            $display("FAIL reload_ctrl: start=%b cpu_rst=%b count=%0d expected 0/0/0",
                     bus.start_o, bus.cpu_rst_o, bus.word_count_o);
        end
        @(negedge clk_i);
        bus.load_i = 1'b0;
        got.delete();
        gen_program(4, 1'b1);
        build_expected();
        send_program(1'b1, tmo);
        wait_done(ok);
        compared++;
        if (tmo != 0 || !ok || got.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL reload_size: writes=%0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) begin
                mismatched++;
                $display("FAIL reload_write[%0d]: got %h@%0d expected %h@%0d", i,
                         got[i].data, got[i].addr, exp_q[i].data, exp_q[i].addr);
            end
        end
    endtask

    initial begin
        rst_i            = 1'b0;
        bus.load_i       = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        test_reset();
        test_example();
        test_random_programs();
        test_full();
        test_restart();
        test_collision();
        test_reset_in_fill();
        test_reload_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, 256, instruction-memory words; address width 8.
REQ-002 Parameter BASE_OFFSET, 2, word index receiving the first loaded word.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 load_i  input  1  one-cycle request to begin a (re)load.
REQ-006 byte_valid_i  input  1  byte_data_i valid.
REQ-007 byte_data_i  input  8  program byte; little-endian within a word.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 mem_we_o  output  1  instruction-memory write strobe.
REQ-010 mem_addr_o  output  8  word address to write.
REQ-011 mem_data_o  output  32  word to write.
REQ-012 cpu_rst_o  output  1  active-low reset to the CPU; low while loading.
REQ-013 start_o  output  1  CPU start; high only in DONE.
REQ-014 word_count_o  output  9  program words written, end marker included.

Function
REQ-015 The block SHALL be an FSM with states IDLE, LOAD, FILL and DONE.
REQ-016 A byte SHALL be accepted when byte_valid_i and byte_ready_o are both high; byte_ready_o SHALL be high only in LOAD with no write pending.
REQ-017 Accepted bytes 0..3 of a word SHALL land in bits [7:0], [15:8], [23:16], [31:24] in that order.
REQ-018 On acceptance of byte 3, the next cycle SHALL present mem_we_o=1, the assembled word on mem_data_o and the address per REQ-019 (1-cycle latency).
REQ-019 Word n (n from 0) SHALL be written at mem_addr_o = (BASE_OFFSET + n) mod DEPTH; e.g. n=254 -> 0, n=255 -> 1.
REQ-020 mem_we_o SHALL be high for exactly one cycle per written word; byte_ready_o SHALL be low in that cycle.
REQ-021 IDLE -> LOAD on load_i; the byte lane, n and word_count_o SHALL clear to 0.
REQ-022 LOAD -> FILL after writing a word equal to 32'h0 (end marker, which is itself written and counted).
REQ-023 LOAD -> DONE after writing word n = DEPTH-1 without an end marker; no further bytes are accepted.
REQ-024 FILL SHALL write 32'h0 once per cycle at the remaining addresses (n+1 .. DEPTH-1, mapped per REQ-019), then enter DONE; FILL writes do not increment word_count_o.
REQ-025 In DONE: cpu_rst_o=1, start_o=1, byte_ready_o=0, mem_we_o=0.
REQ-026 In IDLE, LOAD and FILL: cpu_rst_o=0, start_o=0.
REQ-027 load_i in DONE SHALL start a new load (-> LOAD, counters cleared) and drop cpu_rst_o and start_o the next cycle.
REQ-028 load_i in LOAD or FILL SHALL restart the load: the partial word is discarded, no write for it is issued, and n returns to 0.
REQ-029 If load_i coincides with byte acceptance, the restart SHALL win and the byte SHALL be dropped.
REQ-030 byte_valid_i outside LOAD SHALL be ignored.
REQ-031 word_count_o SHALL saturate at DEPTH (256).

Reset
REQ-032 With rst_i low, the block SHALL asynchronously enter IDLE with mem_we_o=0, mem_addr_o=0, mem_data_o=0, byte_ready_o=0, cpu_rst_o=0, start_o=0, word_count_o=0 and the byte lane cleared.
REQ-033 Reset during LOAD or FILL SHALL abort with no further writes; after rst_i rises the block stays in IDLE until load_i.

Verification
REQ-034 load_i; bytes 13 05 00 00, then 00 00 00 00 -> write 32'h00000513 @2, write 0 @3, FILL zeros @4..255 then 0..1, DONE, word_count_o=2, start_o=1.
REQ-035 Stream 256 nonzero words -> last two at addresses 0 and 1, no FILL, DONE, word_count_o=256, byte_ready_o=0.
REQ-036 byte_valid_i toggling every other cycle -> identical writes and values to the gap-free stream; exactly one mem_we_o pulse per 4 accepted bytes.
REQ-037 load_i after 2 bytes of word 1 -> partial word discarded; next full word written @2.
REQ-038 rst_i low in FILL -> mem_we_o=0 and cpu_rst_o=0 immediately; no writes until load_i.
REQ-039 load_i in DONE -> start_o=0 and cpu_rst_o=0 next cycle; reload writes from address 2.
